// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // Widest supported data word; narrower words are zero-extended before use.
  localparam int unsigned MaxDataBits = 9;

  // True when data plus received parity bit do not match the selected parity sense.
  function automatic logic parity_mismatch(input logic [MaxDataBits-1:0] data,
                                           input logic                   par_bit,
                                           input logic                   odd);
    return ((^data) ^ par_bit) != odd;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the asynchronous rx pad; idles (and resets) high.
module uart_sync2 (
  input  logic clk,
  input  logic areset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops; reset to the line's idle level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_param.sv
// Oversampled UART receiver with configurable frame format and a valid/ready holding register.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam logic [TickW-1:0] HalfLast = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] BitLast  = TickW'(OVERSAMPLE - 1);
  localparam logic [3:0] DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0] StopLast = 4'(STOP_BITS - 1);

  logic                 w_rxs;
  logic                 w_bit_end;
  uart_state_e          r_state;
  logic [TickW-1:0]     r_tick_cnt;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_armed;
  logic                 r_done;

  uart_sync2 u_sync (
    .clk      (clk),
    .areset_n (areset_n),
    .i_d      (rx),
    .o_q      (w_rxs)
  );

  // Mid-bit sample point for data, parity and stop bits.
  assign w_bit_end = baud_tick && (r_tick_cnt == BitLast);
  assign busy      = (r_state != IDLE);

  // Frame FSM: bit timing, deserialisation and per-frame error capture.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_armed    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_tick_cnt <= '0;
          // A low line only starts a frame once it has been seen high (break re-arm).
          if (w_rxs) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_state   <= START;
            r_bit_cnt <= '0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
          end
        end
        START: begin
          if (baud_tick) begin
            if (r_tick_cnt == HalfLast) begin
              r_tick_cnt <= '0;
              r_state    <= w_rxs ? IDLE : DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_tick_cnt <= '0;
            r_shift    <= {w_rxs, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == DataLast) begin
              r_bit_cnt <= '0;
              r_state   <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else if (baud_tick) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_tick_cnt <= '0;
            r_perr     <= parity_mismatch(MaxDataBits'(r_shift), w_rxs, PARITY_ODD != 0);
            r_state    <= STOP;
          end else if (baud_tick) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_tick_cnt <= '0;
            if (!w_rxs) r_ferr <= 1'b1;
            if (r_bit_cnt == StopLast) begin
              r_bit_cnt <= '0;
              r_state   <= IDLE;
              r_done    <= 1'b1;
              // A low final stop sample (break) must see the line go high before re-arming.
              r_armed   <= w_rxs;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else if (baud_tick) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Holding register: load on completion if free (or freed this clk), else flag overrun.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (r_done && (!out_valid || out_ready)) begin
        out_data   <= r_shift;
        parity_err <= r_perr;
        frame_err  <= r_ferr;
        out_valid  <= 1'b1;
      end else begin
        if (out_valid && out_ready) out_valid <= 1'b0;
        if (r_done) overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: five instances with different frame formats share clock and baud tick.
module tb_uart_rx_param;

  localparam int NCFG     = 5;
  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = OS * TICK_DIV;
  localparam int CFG_DB [NCFG] = '{8, 8, 8, 5, 9};
  localparam int CFG_PE [NCFG] = '{0, 1, 0, 1, 0};
  localparam int CFG_PO [NCFG] = '{0, 0, 0, 1, 0};
  localparam int CFG_SB [NCFG] = '{1, 1, 2, 2, 1};

  typedef struct {
    int         idx;
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } cap_t;

  logic clk       = 1'b0;
  logic areset_n  = 1'b0;
  logic baud_tick = 1'b0;
  logic [NCFG-1:0]      rx        = '1;
  logic [NCFG-1:0]      out_ready = '1;
  logic [NCFG-1:0][8:0] dat;
  logic [NCFG-1:0]      vld, perr, ferr, ovr, bsy;

  int   n_pass  = 0;
  int   n_total = 0;
  cap_t caps[$];
  int   ovr_cnt [NCFG];
  int   vld_cyc [NCFG];
  bit   abort_tx = 1'b0;
  int   tcnt = 0;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    logic [CFG_DB[g]-1:0] d;
    uart_rx_param #(
      .DATA_BITS  (CFG_DB[g]),
      .OVERSAMPLE (OS),
      .PARITY_EN  (CFG_PE[g]),
      .PARITY_ODD (CFG_PO[g]),
      .STOP_BITS  (CFG_SB[g])
    ) u_dut (
      .clk        (clk),
      .areset_n   (areset_n),
      .baud_tick  (baud_tick),
      .rx         (rx[g]),
      .out_data   (d),
      .out_valid  (vld[g]),
      .out_ready  (out_ready[g]),
      .parity_err (perr[g]),
      .frame_err  (ferr[g]),
      .overrun    (ovr[g]),
      .busy       (bsy[g])
    );
    assign dat[g] = 9'(d);
  end

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tcnt      <= (tcnt + 1) % TICK_DIV;
    baud_tick <= (tcnt == TICK_DIV - 1);
  end

  // Monitor: inputs only change on the falling edge, so +2 sees what the next rising edge sees.
  always @(negedge clk) begin
    #2;
    for (int i = 0; i < NCFG; i++) begin
      if (vld[i] && out_ready[i]) caps.push_back('{i, dat[i], perr[i], ferr[i]});
      if (ovr[i]) ovr_cnt[i]++;
      if (vld[i]) vld_cyc[i]++;
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "timeout");
  end

  // Reference model: what a frame should deliver, straight from the frame-format rules.
  function automatic cap_t model(input int idx, input logic [8:0] data, input logic par,
                                 input logic s0, input logic s1);
    cap_t c;
    int   ones;
    c.idx = idx;
    c.d   = '0;
    for (int b = 0; b < CFG_DB[idx]; b++) c.d[b] = data[b];
    ones = $countones(c.d) + int'(par);
    c.pe = (CFG_PE[idx] != 0) && ((ones % 2) != CFG_PO[idx]);
    c.fe = !s0 || ((CFG_SB[idx] == 2) && !s1);
    return c;
  endfunction

  task automatic clear_mon();
    caps.delete();
    for (int i = 0; i < NCFG; i++) begin
      ovr_cnt[i] = 0;
      vld_cyc[i] = 0;
    end
  endtask

  task automatic idle_bits(input int n);
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  task automatic hold_bit(input int idx, input logic v);
    rx[idx] = v;
    for (int k = 0; k < BIT_CLKS; k++) begin
      if (abort_tx) begin
        rx[idx] = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input int idx, input logic [8:0] data, input logic par,
                            input logic s0, input logic s1);
    hold_bit(idx, 1'b0);
    for (int b = 0; b < CFG_DB[idx]; b++) hold_bit(idx, data[b]);
    if (CFG_PE[idx] != 0) hold_bit(idx, par);
    hold_bit(idx, s0);
    if (CFG_SB[idx] == 2) hold_bit(idx, s1);
    rx[idx] = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < NCFG; i++) begin
      n_total++;
      if ({vld[i], perr[i], ferr[i], ovr[i], bsy[i], dat[i]} !== 14'h0)
        $display("FAIL reset_outputs[%0d]: got %h want 0", i,
                 {vld[i], perr[i], ferr[i], ovr[i], bsy[i], dat[i]});
      else n_pass++;
    end
    areset_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_8n1();
    clear_mon();
    out_ready = '1;
    send_frame(0, 9'h0A5, 1'b0, 1'b1, 1'b1);
    idle_bits(2);
    n_total++;
    if (caps.size() !== 1) $display("FAIL 8n1_count: got %0d want 1", caps.size());
    else n_pass++;
    if (caps.size() > 0) begin
      n_total++;
      if ({caps[0].d, caps[0].pe, caps[0].fe} !== {9'h0A5, 2'b00})
        $display("FAIL 8n1_word: got d=%h pe=%b fe=%b want d=a5 pe=0 fe=0",
                 caps[0].d, caps[0].pe, caps[0].fe);
      else n_pass++;
    end
    n_total++;
    if (vld_cyc[0] !== 1) $display("FAIL 8n1_valid_cycles: got %0d want 1", vld_cyc[0]);
    else n_pass++;
  endtask

  task automatic test_parity();
    cap_t e0, e1;
    clear_mon();
    e0 = model(1, 9'h003, 1'b1, 1'b1, 1'b1);
    e1 = model(1, 9'h003, 1'b0, 1'b1, 1'b1);
    send_frame(1, 9'h003, 1'b1, 1'b1, 1'b1);
    idle_bits(1);
    send_frame(1, 9'h003, 1'b0, 1'b1, 1'b1);
    idle_bits(2);
    n_total++;
    if (caps.size() !== 2) $display("FAIL parity_count: got %0d want 2", caps.size());
    else n_pass++;
    if (caps.size() > 1) begin
      n_total++;
      if ({caps[0].d, caps[0].pe, caps[0].fe} !== {e0.d, e0.pe, e0.fe})
        $display("FAIL parity_bad: got d=%h pe=%b want d=%h pe=%b",
                 caps[0].d, caps[0].pe, e0.d, e0.pe);
      else n_pass++;
      n_total++;
      if ({caps[1].d, caps[1].pe, caps[1].fe} !== {e1.d, e1.pe, e1.fe})
        $display("FAIL parity_good: got d=%h pe=%b want d=%h pe=%b",
                 caps[1].d, caps[1].pe, e1.d, e1.pe);
      else n_pass++;
    end
  endtask

  task automatic test_stop2();
    clear_mon();
    send_frame(2, 9'h07E, 1'b0, 1'b1, 1'b0);
    idle_bits(1);
    send_frame(2, 9'h081, 1'b0, 1'b1, 1'b1);
    idle_bits(2);
    n_total++;
    if (caps.size() !== 2) $display("FAIL stop2_count: got %0d want 2", caps.size());
    else n_pass++;
    if (caps.size() > 1) begin
      n_total++;
      if ({caps[0].d, caps[0].fe} !== {9'h07E, 1'b1})
        $display("FAIL stop2_ferr: got d=%h fe=%b want d=7e fe=1", caps[0].d, caps[0].fe);
      else n_pass++;
      n_total++;
      if ({caps[1].d, caps[1].fe} !== {9'h081, 1'b0})
        $display("FAIL stop2_rearm: got d=%h fe=%b want d=81 fe=0", caps[1].d, caps[1].fe);
      else n_pass++;
    end
  endtask

  task automatic test_false_start();
    clear_mon();
    rx[0] = 1'b0;
    repeat (15) @(negedge clk);
    n_total++;
    if (bsy[0] !== 1'b1) $display("FAIL false_start_busy: got %b want 1", bsy[0]);
    else n_pass++;
    repeat (5) @(negedge clk);
    rx[0] = 1'b1;
    idle_bits(3);
    n_total++;
    if ({bsy[0], vld[0], perr[0], ferr[0]} !== 4'b0)
      $display("FAIL false_start_idle: got busy/valid/perr/ferr=%b want 0000",
               {bsy[0], vld[0], perr[0], ferr[0]});
    else n_pass++;
    n_total++;
    if (caps.size() + ovr_cnt[0] !== 0)
      $display("FAIL false_start_none: got %0d words %0d overruns want 0", caps.size(), ovr_cnt[0]);
    else n_pass++;
  endtask

  task automatic test_break();
    clear_mon();
    rx[0] = 1'b0;
    idle_bits(13);
    rx[0] = 1'b1;
    idle_bits(2);
    send_frame(0, 9'h05A, 1'b0, 1'b1, 1'b1);
    idle_bits(2);
    n_total++;
    if (caps.size() !== 2) $display("FAIL break_count: got %0d want 2", caps.size());
    else n_pass++;
    if (caps.size() > 1) begin
      n_total++;
      if ({caps[0].d, caps[0].pe, caps[0].fe} !== {9'h000, 2'b01})
        $display("FAIL break_word: got d=%h pe=%b fe=%b want d=0 pe=0 fe=1",
                 caps[0].d, caps[0].pe, caps[0].fe);
      else n_pass++;
      n_total++;
      if ({caps[1].d, caps[1].fe} !== {9'h05A, 1'b0})
        $display("FAIL break_rearm: got d=%h fe=%b want d=5a fe=0", caps[1].d, caps[1].fe);
      else n_pass++;
    end
  endtask

  task automatic test_overrun();
    clear_mon();
    out_ready[0] = 1'b0;
    send_frame(0, 9'h011, 1'b0, 1'b1, 1'b1);
    idle_bits(1);
    send_frame(0, 9'h022, 1'b0, 1'b1, 1'b1);
    idle_bits(1);
    n_total++;
    if ({vld[0], dat[0]} !== {1'b1, 9'h011})
      $display("FAIL overrun_hold: got v=%b d=%h want v=1 d=11", vld[0], dat[0]);
    else n_pass++;
    n_total++;
    if (ovr_cnt[0] !== 1) $display("FAIL overrun_pulses: got %0d want 1", ovr_cnt[0]);
    else n_pass++;
    out_ready[0] = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (caps.size() !== 1 || vld[0] !== 1'b0)
      $display("FAIL overrun_drain: got %0d words v=%b want 1 word v=0", caps.size(), vld[0]);
    else n_pass++;
    if (caps.size() > 0) begin
      n_total++;
      if (caps[0].d !== 9'h011) $display("FAIL overrun_word: got %h want 11", caps[0].d);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    bit seen_busy, seen_idle;
    clear_mon();
    out_ready[0] = 1'b0;
    send_frame(0, 9'h033, 1'b0, 1'b1, 1'b1);
    idle_bits(1);
    seen_busy = 1'b0;
    seen_idle = 1'b0;
    fork
      send_frame(0, 9'h044, 1'b0, 1'b1, 1'b1);
      begin
        for (int k = 0; k < 4 * BIT_CLKS && !seen_busy; k++) begin
          @(negedge clk);
          seen_busy = bsy[0];
        end
        for (int k = 0; k < 16 * BIT_CLKS && seen_busy && !seen_idle; k++) begin
          @(negedge clk);
          seen_idle = !bsy[0];
        end
        // Ready rises exactly on the completion clock.
        if (seen_idle) out_ready[0] = 1'b1;
      end
    join
    idle_bits(1);
    n_total++;
    if ({seen_busy, seen_idle} !== 2'b11)
      $display("FAIL b2b_timing: got busy/idle seen=%b%b want 11", seen_busy, seen_idle);
    else n_pass++;
    n_total++;
    if (caps.size() !== 2) $display("FAIL b2b_count: got %0d want 2", caps.size());
    else n_pass++;
    if (caps.size() > 1) begin
      n_total++;
      if ({caps[0].d, caps[1].d} !== {9'h033, 9'h044})
        $display("FAIL b2b_words: got %h,%h want 33,44", caps[0].d, caps[1].d);
      else n_pass++;
    end
    n_total++;
    if (ovr_cnt[0] !== 0 || vld[0] !== 1'b0)
      $display("FAIL b2b_no_overrun: got ovr=%0d v=%b want 0 0", ovr_cnt[0], vld[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    clear_mon();
    out_ready[0] = 1'b0;
    send_frame(0, 9'h00F, 1'b0, 1'b1, 1'b1);
    idle_bits(1);
    fork
      send_frame(0, 9'h03C, 1'b0, 1'b1, 1'b1);
      begin
        repeat (3 * BIT_CLKS) @(negedge clk);
        n_total++;
        if ({bsy[0], vld[0]} !== 2'b11)
          $display("FAIL reset_mid_pre: got busy/valid=%b want 11", {bsy[0], vld[0]});
        else n_pass++;
        areset_n = 1'b0;
        abort_tx = 1'b1;
        #1;
        n_total++;
        if ({vld[0], perr[0], ferr[0], ovr[0], bsy[0], dat[0]} !== 14'h0)
          $display("FAIL reset_mid_outputs: got %h want 0",
                   {vld[0], perr[0], ferr[0], ovr[0], bsy[0], dat[0]});
        else n_pass++;
        repeat (2) @(negedge clk);
        areset_n = 1'b1;
      end
    join
    abort_tx = 1'b0;
    rx[0] = 1'b1;
    out_ready[0] = 1'b1;
    idle_bits(2);
    n_total++;
    if (caps.size() !== 0 || vld[0] !== 1'b0)
      $display("FAIL reset_mid_discard: got %0d words v=%b want 0 0", caps.size(), vld[0]);
    else n_pass++;
    send_frame(0, 9'h05A, 1'b0, 1'b1, 1'b1);
    idle_bits(2);
    n_total++;
    if (caps.size() !== 1) $display("FAIL reset_mid_next_count: got %0d want 1", caps.size());
    else n_pass++;
    if (caps.size() > 0) begin
      n_total++;
      if ({caps[0].d, caps[0].pe, caps[0].fe} !== {9'h05A, 2'b00})
        $display("FAIL reset_mid_next: got d=%h pe=%b fe=%b want d=5a 0 0",
                 caps[0].d, caps[0].pe, caps[0].fe);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    cap_t exp_q[$];
    cap_t e;
    logic [8:0] data;
    logic par, s0, s1;
    clear_mon();
    out_ready = '1;
    for (int c = 0; c < NCFG; c++) begin
      for (int f = 0; f < 4; f++) begin
        data = 9'($urandom);
        par  = 1'($urandom);
        s0   = ($urandom_range(3) != 0);
        s1   = ($urandom_range(3) != 0);
        exp_q.push_back(model(c, data, par, s0, s1));
        send_frame(c, data, par, s0, s1);
        idle_bits(1);
      end
    end
    idle_bits(1);
    n_total++;
    if (caps.size() !== exp_q.size())
      $display("FAIL random_count: got %0d want %0d", caps.size(), exp_q.size());
    else n_pass++;
    for (int k = 0; k < exp_q.size() && k < caps.size(); k++) begin
      e = exp_q[k];
      n_total++;
      if ({caps[k].idx, caps[k].d, caps[k].pe, caps[k].fe} !== {e.idx, e.d, e.pe, e.fe})
        $display("FAIL random_word[%0d]: got cfg=%0d d=%h pe=%b fe=%b want cfg=%0d d=%h pe=%b fe=%b",
                 k, caps[k].idx, caps[k].d, caps[k].pe, caps[k].fe, e.idx, e.d, e.pe, e.fe);
      else n_pass++;
    end
    n_total++;
    if (ovr_cnt.sum() !== 0) $display("FAIL random_overrun: got %0d want 0", ovr_cnt.sum());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_stop2();
    test_false_start();
    test_break();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
